// File: rtl/dec_3to8_seq.sv
// Buffered 3-to-8 decoder: codes arrive over valid/ready into a small FIFO and
// are shown one at a time as one-hot patterns, each held for HOLD cycles.
module dec_3to8_seq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned HOLD  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 x,
  input  logic                       x_valid,
  output logic                       x_ready,
  output logic [7:0]                 y,
  output logic                       y_valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic {IDLE, SHOW} state_t;

  logic [2:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  state_t        state_q, state_d;
  logic [7:0]    y_q, y_d;
  logic          y_valid_q, y_valid_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          push, pop;

  // Ready depends only on occupancy, so a pop never lets a push through early.
  assign x_ready = (count_q != CW'(DEPTH));
  assign push    = x_valid & x_ready;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= x;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      timer_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      state_q   <= state_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      timer_q   <= timer_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    timer_d   = timer_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          y_d       = 8'd1 << mem_q[rd_ptr_q];
          y_valid_d = 1'b1;
          timer_d   = TW'(HOLD - 1);
          state_d   = SHOW;
        end
      end
      SHOW: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else if (count_q != '0) begin
          // Chain straight into the next code so there is no blank cycle.
          pop       = 1'b1;
          y_d       = 8'd1 << mem_q[rd_ptr_q];
          timer_d   = TW'(HOLD - 1);
        end else begin
          y_d       = '0;
          y_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign count   = count_q;

endmodule

// File: tb/tb_dec_3to8_seq.sv
// Scoreboard bench: two decoders (HOLD=3 and HOLD=1) driven by directed and
// random code streams, checked cycle by cycle against a queue-based model.
module tb_dec_3to8_seq;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0][2:0] x_s;
  logic [1:0]      xv_s;
  logic [1:0]      xr_s;
  logic [1:0][7:0] y_s;
  logic [1:0]      yv_s;
  logic [1:0][2:0] cnt_s;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp_v, exp_v);
    end
  endtask

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_ch
    localparam int HOLDV = (gi == 0) ? 3 : 1;

    dec_3to8_seq #(.DEPTH(DEPTH), .HOLD(HOLDV)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .x       (x_s[gi]),
      .x_valid (xv_s[gi]),
      .x_ready (xr_s[gi]),
      .y       (y_s[gi]),
      .y_valid (yv_s[gi]),
      .count   (cnt_s[gi])
    );

    // Model: sb holds accepted codes not yet shown; hold_rem counts the
    // remaining cycles of the pattern currently on y.
    int         sb[$];
    int         hold_rem = 0;
    int         cur      = 0;
    bit         pend     = 0;
    logic [2:0] pend_x   = '0;
    bit         must_show = 0;

    always @(negedge clk) begin
      if (rst) begin
        sb.delete();
        hold_rem  = 0;
        pend      = 0;
        must_show = 0;
        check($sformatf("d%0d_rst_y", gi), int'(y_s[gi]), 0);
        check($sformatf("d%0d_rst_yvalid", gi), int'(yv_s[gi]), 0);
        check($sformatf("d%0d_rst_count", gi), int'(cnt_s[gi]), 0);
      end else begin
        if (must_show) check($sformatf("d%0d_no_gap", gi), int'(yv_s[gi]), 1);
        if (yv_s[gi]) begin
          if (hold_rem == 0) begin
            if (sb.size() == 0) begin
              check($sformatf("d%0d_stale_show", gi), int'(yv_s[gi]), 0);
            end else begin
              cur      = sb.pop_front();
              hold_rem = HOLDV - 1;
              check($sformatf("d%0d_y", gi), int'(y_s[gi]), 1 << cur);
            end
          end else begin
            hold_rem--;
            check($sformatf("d%0d_y_hold", gi), int'(y_s[gi]), 1 << cur);
          end
        end else begin
          check($sformatf("d%0d_idle_y", gi), int'(y_s[gi]), 0);
          check($sformatf("d%0d_hold_len", gi), hold_rem, 0);
          hold_rem = 0;
        end
        if (pend) sb.push_back(int'(pend_x));
        check($sformatf("d%0d_count", gi), int'(cnt_s[gi]), sb.size());
        check($sformatf("d%0d_x_ready", gi), int'(xr_s[gi]), int'(sb.size() != DEPTH));
        must_show = (!yv_s[gi] || hold_rem == 0) && (sb.size() != 0);
        pend   = xv_s[gi] && xr_s[gi];
        pend_x = x_s[gi];
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int i, input logic [2:0] code);
    logic r;
    x_s[i]  = code;
    xv_s[i] = 1'b1;
    for (int c = 0; c < 100; c++) begin
      r = xr_s[i];
      cyc(1);
      if (r) return;
    end
    check("send_timeout", int'(xr_s[i]), 1);
  endtask

  task automatic idle(input int i, input int n);
    xv_s[i] = 1'b0;
    cyc(n);
  endtask

  task automatic wait_idle(input int i);
    for (int c = 0; c < 200; c++) begin
      if (cnt_s[i] == '0 && !yv_s[i]) return;
      cyc(1);
    end
    check("drain_timeout", int'(cnt_s[i]) + int'(yv_s[i]), 0);
  endtask

  logic [1:0] rdy_prev;

  initial begin
    x_s  = '0;
    xv_s = '0;
    #1 rst = 1'b1;
    #2;
    check("init_y", int'(y_s[0]), 0);
    check("init_count", int'(cnt_s[0]), 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("init_ready", int'(xr_s[0]), 1);
    cyc(1);

    // Single code into an idle block.
    send(0, 3'd5);
    idle(0, 1);
    wait_idle(0);
    cyc(2);

    // Back-to-back codes.
    send(0, 3'd0); send(0, 3'd7); send(0, 3'd3);
    idle(0, 1);
    wait_idle(0);
    cyc(2);

    // Sustained valid fills the FIFO.
    for (int k = 1; k <= 7; k++) send(0, 3'(k));
    idle(0, 1);
    wait_idle(0);
    cyc(2);

    // Push lands on the same edge as a pop at count 2.
    send(0, 3'd2); send(0, 3'd4); send(0, 3'd6);
    idle(0, 1);
    send(0, 3'd1);
    idle(0, 1);
    wait_idle(0);
    cyc(2);

    // HOLD=1 walk through all codes.
    for (int k = 0; k < 8; k++) send(1, 3'(k));
    idle(1, 1);
    wait_idle(1);
    cyc(2);

    // Asynchronous reset while 8'h20 is displayed.
    send(0, 3'd5); send(0, 3'd1);
    idle(0, 0);
    for (int c = 0; c < 20; c++) begin
      if (y_s[0] == 8'h20) break;
      cyc(1);
    end
    #1 rst = 1'b1;
    #1;
    check("async_rst_y", int'(y_s[0]), 0);
    check("async_rst_yvalid", int'(yv_s[0]), 0);
    check("async_rst_count", int'(cnt_s[0]), 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("ready_after_rst", int'(xr_s[0]), 1);
    cyc(4);

    // Random traffic on both decoders; a refused code is held stable.
    rdy_prev = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(xv_s[i] && !rdy_prev[i])) begin
          xv_s[i] = ($urandom_range(0, 3) != 0);
          x_s[i]  = 3'($urandom_range(0, 7));
        end
        rdy_prev[i] = xr_s[i];
      end
      cyc(1);
    end
    idle(0, 0);
    idle(1, 1);
    wait_idle(0);
    wait_idle(1);
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
